// File: rtl/serial_sub4_if.sv
// Request/result bundle for the bit-serial subtractor.
// Signal prefixes are from the subtractor's point of view.
interface serial_sub4_if #(
    parameter int WIDTH = 4
);
    logic             i_start;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic [WIDTH-1:0] o_out;
    logic             o_borrow;
    logic             o_busy;
    logic             o_done;

    modport slave (
        input  i_start, i_a, i_b,
        output o_out, o_borrow, o_busy, o_done
    );

    modport master (
        output i_start, i_a, i_b,
        input  o_out, o_borrow, o_busy, o_done
    );
endinterface

// File: rtl/serial_sub4.sv
// Bit-serial unsigned subtractor: one difference bit per clock, LSB first.
// The result and final borrow are registered and held until the next completion.
module serial_sub4 #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    serial_sub4_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [WIDTH-1:0] r_out;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic             r_borrow;

    logic             w_accept;
    logic             w_last;
    logic             w_diff;
    logic             w_br_next;
    logic [WIDTH-1:0] w_res_next;
    logic             w_busy;
    logic             w_done;

    // Full-subtractor slice on the current LSBs of the operand shifters.
    assign w_diff     = r_a[0] ^ r_b[0] ^ r_br;
    assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
    assign w_res_next = {w_diff, r_res[WIDTH-1:1]};
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_accept   = (r_state == IDLE) && bus.i_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                w_busy = 1'b1;
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_res    <= '0;
            r_cnt    <= '0;
            r_br     <= 1'b0;
            r_out    <= '0;
            r_borrow <= 1'b0;
        end else if (w_accept) begin
            r_a   <= bus.i_a;
            r_b   <= bus.i_b;
            r_res <= '0;
            r_cnt <= '0;
            r_br  <= 1'b0;
        end else if (r_state == RUN) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= w_res_next;
            r_br  <= w_br_next;
            r_cnt <= r_cnt + CW'(1);
            // Publish on the final bit so out/borrow never show a partial result.
            if (w_last) begin
                r_out    <= w_res_next;
                r_borrow <= w_br_next;
            end
        end
    end

    assign bus.o_out    = r_out;
    assign bus.o_borrow = r_borrow;
    assign bus.o_busy   = w_busy;
    assign bus.o_done   = w_done;
endmodule

// File: tb/tb_serial_sub4.sv
// Directed and exhaustive checks of the serial subtractor, sampled on the falling edge.
module tb_serial_sub4;
    localparam int WIDTH = 4;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    logic [WIDTH-1:0] prev_out;
    logic             prev_br;

    serial_sub4_if #(.WIDTH(WIDTH)) bus ();

    serial_sub4 #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    // One operation; mode 0 plain, 1 re-pulse start mid-run, 2 scramble a/b during run.
    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                         input logic [WIDTH-1:0] eo, input logic eb, input int mode);
        int nb, nd, nboth, nchg, dcyc;
        logic [WIDTH-1:0] got_o;
        logic             got_b;
        nb = 0; nd = 0; nboth = 0; nchg = 0; dcyc = -1;
        got_o = '0; got_b = 1'b0;
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_a = ta; bus.i_b = tb_;
        @(negedge clk);
        bus.i_start = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (bus.o_busy) begin
                nb++;
                if (bus.o_out !== prev_out || bus.o_borrow !== prev_br) nchg++;
            end
            if (bus.o_done) begin
                nd++;
                dcyc  = cyc;
                got_o = bus.o_out;
                got_b = bus.o_borrow;
            end
            if (bus.o_busy && bus.o_done) nboth++;
            if (mode == 1 && cyc == 0) begin
                bus.i_start = 1'b1; bus.i_a = 4'd1; bus.i_b = 4'd1;
            end else if (mode == 1 && cyc == 1) begin
                bus.i_start = 1'b0;
            end
            if (mode == 2) begin
                bus.i_a = WIDTH'($urandom_range(0, 15));
                bus.i_b = WIDTH'($urandom_range(0, 15));
            end
            @(negedge clk);
        end
        chk($sformatf("out %0d-%0d", ta, tb_), got_o, eo);
        chk($sformatf("borrow %0d-%0d", ta, tb_), got_b, eb);
        chk("done count", nd, 1);
        chk("busy cycles", nb, WIDTH);
        chk("done latency", dcyc, WIDTH);
        chk("busy&done", nboth, 0);
        chk("hold in run", nchg, 0);
        prev_out = eo;
        prev_br  = eb;
    endtask

    initial begin
        int nd, nb;
        n_vec = 0; n_bad = 0;
        prev_out = '0; prev_br = 1'b0;
        bus.i_start = 1'b0; bus.i_a = '0; bus.i_b = '0;
        rst = 1'b1;
        #1;
        chk("rst out", bus.o_out, 0);
        chk("rst borrow", bus.o_borrow, 0);
        chk("rst busy", bus.o_busy, 0);
        chk("rst done", bus.o_done, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_op(4'd9,  4'd3,  4'd6,  1'b0, 0);
        do_op(4'd3,  4'd9,  4'd10, 1'b1, 0);
        do_op(4'd15, 4'd15, 4'd0,  1'b0, 0);
        do_op(4'd0,  4'd1,  4'd15, 1'b1, 0);
        do_op(4'd9,  4'd3,  4'd6,  1'b0, 1);
        do_op(4'd12, 4'd5,  4'd7,  1'b0, 2);
        do_op(4'd2,  4'd14, 4'd4,  1'b1, 2);

        // start held high across DONE is taken on the first IDLE edge
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_a = 4'd5; bus.i_b = 4'd2;
        repeat (5) @(negedge clk);
        chk("held: done", bus.o_done, 1);
        chk("held: out", bus.o_out, 3);
        @(negedge clk);
        chk("held: idle busy", bus.o_busy, 0);
        chk("held: idle done", bus.o_done, 0);
        @(negedge clk);
        bus.i_start = 1'b0;
        chk("held: rerun busy", bus.o_busy, 1);
        repeat (4) @(negedge clk);
        chk("held: second done", bus.o_done, 1);
        chk("held: second out", bus.o_out, 3);
        @(negedge clk);
        prev_out = 4'd3; prev_br = 1'b0;

        // async reset mid-run
        @(negedge clk);
        bus.i_start = 1'b1; bus.i_a = 4'd1; bus.i_b = 4'd2;
        @(negedge clk);
        bus.i_start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst out", bus.o_out, 0);
        chk("arst borrow", bus.o_borrow, 0);
        chk("arst busy", bus.o_busy, 0);
        chk("arst done", bus.o_done, 0);
        @(negedge clk);
        rst = 1'b0;
        nd = 0; nb = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.o_done) nd++;
            if (bus.o_busy) nb++;
        end
        chk("arst no done", nd, 0);
        chk("arst no busy", nb, 0);
        chk("arst out stays", bus.o_out, 0);
        prev_out = '0; prev_br = 1'b0;
        do_op(4'd8, 4'd1, 4'd7, 1'b0, 0);

        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                logic [WIDTH-1:0] xa, xb, xd;
                xa = WIDTH'(ia);
                xb = WIDTH'(ib);
                xd = xa - xb;
                do_op(xa, xb, xd, ia < ib, 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
